// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// mux4_rr_arbiter_pkg : shared types and helpers for the 4-way RR arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input idx_t i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// rr_pick4 : combinational round-robin search of req starting at ptr
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         idx
);

    idx_t cand;

    // Scan from the farthest offset down so the nearest set bit is the last write.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + idx_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// mux4_rr_arbiter : 4-way round-robin arbiter with hold timeout, registered outputs
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic               busy
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state;
    state_t              state_nx;
    logic [NUM_REQ-1:0]  gnt_nx;
    idx_t                sel_nx;
    logic                busy_nx;
    idx_t                ptr;
    idx_t                ptr_nx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nx;

    logic                found;
    idx_t                win;
    logic                owner_req;
    logic                others;
    logic                take;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    // sel always names the current owner while in GRANT.
    assign owner_req = req[sel];
    assign others    = |(req & ~idx_onehot(sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            sel      <= sel_nx;
            busy     <= busy_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        busy_nx  = busy;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        take     = 1'b0;

        case (state)
            IDLE: begin
                take = found;
            end
            GRANT: begin
                if (!owner_req) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        busy_nx  = 1'b0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    // ptr already points past the owner, so win is another requester.
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        hold_nx = '0;
                    end
                end else begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end
        endcase

        if (take) begin
            state_nx = GRANT;
            gnt_nx   = idx_onehot(win);
            sel_nx   = win;
            busy_nx  = 1'b1;
            hold_nx  = '0;
            ptr_nx   = win + idx_t'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles for one owner while another requester waits; legal range 2..255.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port req, input, 4: request per requester i; held high until the requester is done.
REQ-005 Port gnt, output, 4: one-hot grant; zero when no owner.
REQ-006 Port sel, output, 2: binary index of the current or last owner; drives the 4:1 mux select, with sel[1] = s1 and sel[0] = s0.
REQ-007 Port busy, output, 1: high while any gnt bit is high.

Function
REQ-008 The block SHALL use two states: IDLE (no owner) and GRANT (owner held).
REQ-009 All outputs SHALL be registered; gnt, sel and busy change only on clk edges.
REQ-010 IDLE with req != 0 at edge N -> GRANT from edge N, gnt/sel/busy valid in cycle N+1; one-cycle request-to-grant latency.
REQ-011 Winner selection SHALL be round-robin: search req starting at index ptr and wrap 3->0; the first set bit wins.
REQ-012 On every new grant to index w, ptr SHALL become (w+1) mod 4.
REQ-013 In GRANT, hold_cnt SHALL reset to 0 on each new grant and increment by 1 per cycle the grant is retained.
REQ-014 Release: in GRANT, req[owner]=0 at an edge -> pick the next winner at that edge from req; if none, go to IDLE (gnt=0, busy=0).
REQ-015 Handoff SHALL be bubble-free: the new gnt appears in the cycle immediately after the old one, never overlapping it.
REQ-016 Timeout: hold_cnt = MAX_HOLD-1 with req[owner]=1 and another req bit set -> at that edge, grant the next requester per REQ-011; the preempted owner keeps requesting and is rescheduled normally.
REQ-017 Timeout with no other requester -> owner retains the grant and hold_cnt restarts at 0.
REQ-018 When req[owner] drops while the timeout also fires, the release rule (REQ-014) governs; both produce the same winner.
REQ-019 hold_cnt SHALL be ceil(log2(MAX_HOLD)) bits wide and SHALL never wrap past MAX_HOLD-1.
REQ-020 In IDLE, sel SHALL hold the last owner index, so the mux output remains stable.
REQ-021 gnt SHALL be all-zero or exactly one-hot in every cycle.
REQ-022 busy SHALL equal |gnt in every cycle.
REQ-023 Requests arriving during GRANT SHALL NOT disturb the current owner, except through the timeout rule.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force: state=IDLE, gnt=0, sel=0, busy=0, hold_cnt=0, ptr=0.
REQ-025 Reset mid-grant SHALL drop gnt without waiting for a clock edge; no grant SHALL be remembered.
REQ-026 After rst_n deasserts, the first edge with req != 0 SHALL arbitrate from ptr=0.

Structure
REQ-027 A shared package SHALL hold: the state enum (IDLE, GRANT); constant NUM_REQ=4; the index type (2 bits).
REQ-028 A single combinational sub-module rr_pick4 SHALL be used, with inputs req[3:0] and ptr[1:0] and outputs found and idx[1:0]; all sequencing stays in mux4_rr_arbiter.

Verification
REQ-029 After reset, req=0001 held for 3 cycles and then dropped -> gnt=0001 and sel=00 for cycles 1..3; gnt=0000 and busy=0 one cycle after the drop; sel stays 00.
REQ-030 req=1111 constant, MAX_HOLD=4 -> gnt rotates 0001,0010,0100,1000,0001, 4 cycles each, no idle cycles.
REQ-031 Owner 2 releases while req=1011 is pending -> next gnt=1000 (sel=11) in the next cycle, with no overlapping and no zero cycle.
REQ-032 Only req[1]=1, held for 20 cycles, MAX_HOLD=8 -> gnt=0010 continuously, never dropping at a timeout.
REQ-033 rst_n pulsed low mid-grant between clock edges -> gnt, busy and sel go to 0 immediately; the next grant starts from index 0.
REQ-034 Random req for 10k cycles -> assertions: gnt one-hot or zero, busy=|gnt, every requester held high is granted within 3*MAX_HOLD+4 cycles.
